// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO stream reader slice.
// Holds the default data/counter widths and the width helper used to size the
// skid-buffer occupancy, skid-buffer pointers and burst beat counters.
package fifo_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  // Bits needed to hold any value in 0..max_val (at least 1).
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Bundle of the FIFO read port and the output valid/ready stream.
// Signals:
//   fifo_empty / fifo_rdata : from the FIFO
//   fifo_re                 : read enable to the FIFO
//   m_valid/m_data/m_last   : output stream from the reader
//   m_ready                 : consumer ready
// Modports: master = the reader, slave = FIFO plus consumer side.
interface fifo_stream_reader_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              fifo_empty;
  logic              fifo_re;
  logic [DATA_W-1:0] fifo_rdata;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (
    input  fifo_empty, fifo_rdata, m_ready,
    output fifo_re, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_rdata, m_ready,
    input  fifo_re, m_valid, m_data, m_last
  );

endinterface

// File: rtl/fifo_stream_reader_skid_buf.sv
// skid_buf: small register FIFO that absorbs the FIFO read latency.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_push/i_data: write one entry at the tail
//   i_pop        : advance the head
//   o_head       : head entry (register output)
//   o_occ        : current occupancy
// Overflow/underflow are prevented by the caller's read-issue logic.
module skid_buf
  import fifo_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = 2,
  localparam int OCC_W  = cnt_w(DEPTH),
  localparam int PTR_W  = cnt_w(DEPTH - 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic [OCC_W-1:0]  o_occ
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [OCC_W-1:0]  r_occ;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ptr_next(r_wr_ptr);
      end
      if (i_pop) r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_head = r_mem[r_rd_ptr];
  assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous FIFO into a valid/ready stream.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_en         : allow new FIFO reads (buffered/in-flight words still drain)
//   bus          : FIFO read port + output stream (master modport)
//   o_word_cnt   : transferred word count, wraps silently
// The implicit states (empty / filling / streaming / stalled) live entirely in
// the skid occupancy and the in-flight flag; no separate state register.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter  int DATA_W     = DATA_W_DEF,
  parameter  int SKID_DEPTH = 2,
  parameter  int BURST_LEN  = 4,
  parameter  int CNT_W      = CNT_W_DEF,
  localparam int OCC_W      = cnt_w(SKID_DEPTH),
  localparam int BEAT_W     = cnt_w(BURST_LEN - 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  fifo_stream_reader_if.master bus,
  output logic [CNT_W-1:0]     o_word_cnt
);

  logic              r_inflight;
  logic [BEAT_W-1:0] r_beat;
  logic [CNT_W-1:0]  r_word_cnt;
  logic [OCC_W-1:0]  w_occ;
  logic [DATA_W-1:0] w_head;
  logic              w_pop;
  logic              w_last;
  logic [OCC_W:0]    w_fill;
  logic [OCC_W:0]    w_limit;

  assign w_pop = bus.m_valid & bus.m_ready;

  // occ + inflight - pop < SKID_DEPTH, rearranged to avoid an underflowing
  // subtraction; one extra bit keeps the sum from wrapping.
  assign w_fill  = {1'b0, w_occ} + (OCC_W + 1)'(r_inflight);
  assign w_limit = (OCC_W + 1)'(SKID_DEPTH) + (OCC_W + 1)'(w_pop);

  assign bus.fifo_re = i_en & ~bus.fifo_empty & ~i_rst & (w_fill < w_limit);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_inflight <= 1'b0;
    else       r_inflight <= bus.fifo_re;
  end

  // The FIFO returns data one cycle after the accepted read; capture it then.
  skid_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (SKID_DEPTH)
  ) u_skid (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (r_inflight),
    .i_data (bus.fifo_rdata),
    .i_pop  (w_pop),
    .o_head (w_head),
    .o_occ  (w_occ)
  );

  assign bus.m_valid = (w_occ != '0);
  assign bus.m_data  = w_head;
  assign w_last      = bus.m_valid & (r_beat == BEAT_W'(BURST_LEN - 1));
  assign bus.m_last  = w_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_beat     <= '0;
      r_word_cnt <= '0;
    end else if (w_pop) begin
      r_beat     <= w_last ? '0 : r_beat + 1'b1;
      r_word_cnt <= r_word_cnt + 1'b1;
    end
  end

  assign o_word_cnt = r_word_cnt;

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;
  import fifo_pkg::*;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int SD = 2;
  localparam int BL = 4;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [CW-1:0] word_cnt;

  always #5 clk = ~clk;

  fifo_stream_reader_if #(.DATA_W(DW)) bus ();

  fifo_stream_reader #(
    .DATA_W(DW), .SKID_DEPTH(SD), .BURST_LEN(BL), .CNT_W(CW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .bus(bus), .o_word_cnt(word_cnt)
  );

  int checks   = 0;
  int failures = 0;

  exp_t          exp_q[$];
  logic [DW-1:0] fq[$];
  int            re_cyc[$];
  int            pop_cyc[$];
  int            exp_beat = 0;
  int            cyc = 0;
  int            outstanding = 0;
  int            max_out = 0;
  int            valid_seen = 0;
  logic          re_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void push_exp(input logic [DW-1:0] d);
    exp_t e;
    e.d = d;
    e.l = (exp_beat == BL - 1);
    exp_beat = e.l ? 0 : exp_beat + 1;
    exp_q.push_back(e);
  endfunction

  task automatic load_words(input int first, input int n, input bit expect_them);
    for (int i = 0; i < n; i++) begin
      fq.push_back(DW'(first + i));
      if (expect_them) push_exp(DW'(first + i));
    end
    bus.fifo_empty = (fq.size() == 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout actual=%0d_pending required=0", name, exp_q.size());
    end
    @(negedge clk);
    chk({name, "_idle_valid"}, bus.m_valid, 1'b0);
    tick();
  endtask

  // Behavioural syn_fifo read port: data appears the cycle after an accepted read.
  always @(negedge clk) re_seen = bus.fifo_re;

  always @(posedge clk) begin
    #1;
    if (re_seen) begin
      if (fq.size() == 0) begin
        failures++;
        $display("FAIL fifo_underflow actual=read required=no_read");
      end else begin
        bus.fifo_rdata = fq.pop_front();
      end
    end
    bus.fifo_empty = (fq.size() == 0);
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    logic pop;
    cyc++;
    if (rst) begin
      chk("re_in_reset", bus.fifo_re, 1'b0);
      outstanding = 0;
    end else begin
      pop = bus.m_valid && bus.m_ready;
      if (bus.fifo_re) re_cyc.push_back(cyc);
      if (bus.m_valid) valid_seen++;
      if (pop) begin
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word actual=%0h required=none", bus.m_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("m_data", bus.m_data, e.d);
          chk("m_last", bus.m_last, e.l);
        end
      end
      outstanding = outstanding + int'(bus.fifo_re) - int'(pop);
      if (outstanding > max_out) max_out = outstanding;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base_re;
    int base_valid;

    // Reset with data ready and en high: no reads may issue during reset.
    rst = 1'b1;
    en  = 1'b1;
    bus.m_ready    = 1'b1;
    bus.fifo_empty = 1'b1;
    bus.fifo_rdata = '0;
    load_words(1, 4, 1'b1);
    repeat (3) tick();

    // Free-run.
    re_cyc.delete();
    pop_cyc.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_m_valid", bus.m_valid, 1'b0);
    chk("rst_m_last", bus.m_last, 1'b0);
    chk("rst_m_data", bus.m_data, '0);
    chk("rst_word_cnt", word_cnt, '0);
    chk("first_re", bus.fifo_re, 1'b1);
    wait_drain("freerun", 50);
    chk("freerun_re_count", re_cyc.size(), 4);
    if (re_cyc.size() == 4 && pop_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("freerun_re_consecutive", re_cyc[i], re_cyc[0] + i);
      for (int i = 0; i < 4; i++) chk("freerun_latency", pop_cyc[i], re_cyc[0] + 2 + i);
    end
    chk("freerun_word_cnt", word_cnt, 4);
    chk("freerun_re_idle", bus.fifo_re, 1'b0);

    // Backpressure: only SKID_DEPTH reads may be outstanding.
    bus.m_ready = 1'b0;
    re_cyc.delete();
    load_words(1, 4, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 3) chk("bp_hold_data", bus.m_data, 1);
    end
    chk("bp_re_count", re_cyc.size(), SD);
    chk("bp_m_valid", bus.m_valid, 1'b1);
    chk("bp_m_last", bus.m_last, 1'b0);
    chk("bp_occ", outstanding, SD);
    bus.m_ready = 1'b1;
    wait_drain("bp", 50);
    chk("bp_word_cnt", word_cnt, 8);

    // Burst wrap: last on words 4 and 8.
    load_words(1, 8, 1'b1);
    wait_drain("burst", 50);
    chk("burst_word_cnt", word_cnt, 16);

    // Empty FIFO with en high.
    base_re    = re_cyc.size();
    base_valid = valid_seen;
    repeat (10) tick();
    chk("empty_no_re", re_cyc.size(), base_re);
    chk("empty_no_valid", valid_seen, base_valid);

    // en dropped after the first read.
    load_words(11, 4, 1'b0);
    push_exp(11);
    tick();
    en = 1'b0;
    wait_drain("en_drop", 50);
    repeat (3) tick();
    chk("en_drop_re_count", re_cyc.size(), base_re + 1);
    chk("en_drop_fifo_left", fq.size(), 3);
    chk("en_drop_word_cnt", word_cnt, 17);

    // Random m_ready over 64 words (3 leftovers + 61 new).
    push_exp(12);
    push_exp(13);
    push_exp(14);
    load_words(15, 61, 1'b1);
    en = 1'b1;
    for (int n = 0; n < 3000 && exp_q.size() != 0; n++) begin
      bus.m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    bus.m_ready = 1'b1;
    wait_drain("random", 50);
    chk("random_word_cnt", word_cnt, 81);

    // Reset mid-stream: buffered and in-flight words are lost.
    bus.m_ready = 1'b0;
    re_cyc.delete();
    load_words(100, 4, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_re_count", re_cyc.size(), 2);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_m_valid", bus.m_valid, 1'b0);
    chk("mid_rst_word_cnt", word_cnt, '0);
    exp_beat = 0;
    push_exp(102);
    push_exp(103);
    load_words(104, 2, 1'b1);
    bus.m_ready = 1'b1;
    wait_drain("mid_rst", 50);
    chk("mid_rst_final_cnt", word_cnt, 4);
    chk("fifo_all_read", fq.size(), 0);

    chk("skid_occupancy_bound", max_out <= SD, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
